// File: rtl/cmd_executor_if.sv
// Bus bundle between the command executor and its surroundings: command FIFO
// head, single-port memory request/response and the TX response byte stream.
interface cmd_executor_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              cmd_fifo_empty;
   logic              cmd_fifo_rd_en;
   logic [7:0]        cmd_opcode;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;

   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;

   // Executor side.
   modport master (
      input  cmd_fifo_empty, cmd_opcode, cmd_addr, cmd_wdata,
      input  mem_rdata, mem_rvalid, tx_ready,
      output cmd_fifo_rd_en, mem_req, mem_we, mem_addr, mem_wdata,
      output tx_data, tx_valid
   );

   // FIFO / memory / TX side.
   modport slave (
      output cmd_fifo_empty, cmd_opcode, cmd_addr, cmd_wdata,
      output mem_rdata, mem_rvalid, tx_ready,
      input  cmd_fifo_rd_en, mem_req, mem_we, mem_addr, mem_wdata,
      input  tx_data, tx_valid
   );
endinterface

// File: rtl/cmd_executor.sv
// Command executor: pops one decoded command, performs a single memory read or
// write, then streams a response header (and read data, MSB byte first) to TX.
module cmd_executor #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic           clk,
   input  logic           rst,
   cmd_executor_if.master bus,
   output logic           busy,
   output logic [7:0]     err_count
);
   localparam int NB = DATA_W / 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_OK   = 8'h4B;
   localparam logic [7:0] RSP_DATA = 8'h44;
   localparam logic [7:0] RSP_ERR  = 8'h45;
   localparam logic [7:0] RSP_TMO  = 8'h54;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_WRITE     = 3'd2;
   localparam logic [2:0] ST_READ_REQ  = 3'd3;
   localparam logic [2:0] ST_READ_WAIT = 3'd4;
   localparam logic [2:0] ST_SEND_HDR  = 3'd5;
   localparam logic [2:0] ST_SEND_DATA = 3'd6;

   logic [2:0]        state;
   logic [7:0]        opcode_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [7:0]        resp_q;
   logic [IW-1:0]     idx_q;
   logic [TW-1:0]     tmo_q;
   logic              tx_fire;
   logic              err_event;

   // Strobes are also gated by rst so nothing leaves the block while it is
   // held in reset, even before the reset edge has cleared the state.
   assign bus.cmd_fifo_rd_en = rst && (state == ST_IDLE) && !bus.cmd_fifo_empty;
   assign bus.mem_req        = rst && ((state == ST_WRITE) || (state == ST_READ_REQ));
   assign bus.mem_we         = rst && (state == ST_WRITE);
   assign bus.mem_addr       = addr_q;
   assign bus.mem_wdata      = wdata_q;
   assign bus.tx_valid       = rst && ((state == ST_SEND_HDR) || (state == ST_SEND_DATA));
   assign busy               = (state != ST_IDLE);

   assign tx_fire = bus.tx_valid && bus.tx_ready;

   always_comb begin
      // NOTE: default first so every path assigns tx_data and no latch is inferred.
      bus.tx_data = 8'h00;
      case (state)
         ST_SEND_HDR:  bus.tx_data = resp_q;
         ST_SEND_DATA: bus.tx_data = rdata_q[DATA_W-1 -: 8];
         default:      bus.tx_data = 8'h00;
      endcase
   end

   always_comb begin
      err_event = 1'b0;
      if (state == ST_DECODE)
         err_event = (opcode_q != OP_WRITE) && (opcode_q != OP_READ);
      else if (state == ST_READ_WAIT)
         err_event = !bus.mem_rvalid && (tmo_q == TMO_LAST);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         opcode_q  <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
         idx_q     <= '0;
         tmo_q     <= '0;
         err_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!bus.cmd_fifo_empty) begin
                  opcode_q <= bus.cmd_opcode;
                  addr_q   <= bus.cmd_addr;
                  wdata_q  <= bus.cmd_wdata;
                  state    <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (opcode_q == OP_WRITE) begin
                  state <= ST_WRITE;
               end else if (opcode_q == OP_READ) begin
                  state <= ST_READ_REQ;
               end else begin
                  resp_q <= RSP_ERR;
                  state  <= ST_SEND_HDR;
               end
            end
            ST_WRITE: begin
               resp_q <= RSP_OK;
               state  <= ST_SEND_HDR;
            end
            ST_READ_REQ: begin
               tmo_q <= '0;
               state <= ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
               // Data arriving on the last waiting cycle still wins over timeout.
               if (bus.mem_rvalid) begin
                  rdata_q <= bus.mem_rdata;
                  resp_q  <= RSP_DATA;
                  state   <= ST_SEND_HDR;
               end else if (tmo_q == TMO_LAST) begin
                  resp_q <= RSP_TMO;
                  state  <= ST_SEND_HDR;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            ST_SEND_HDR: begin
               if (tx_fire) begin
                  idx_q <= '0;
                  state <= (resp_q == RSP_DATA) ? ST_SEND_DATA : ST_IDLE;
               end
            end
            ST_SEND_DATA: begin
               // Shift the next byte into the top lane once the current one is taken.
               if (tx_fire) begin
                  rdata_q <= rdata_q << 8;
                  if (idx_q == IDX_LAST) begin
                     state <= ST_IDLE;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (err_event && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
      end
   end
endmodule

// File: doc/cmd_executor.md
Name: cmd_executor

Overview:
- Downstream stage of the command parser. Pops decoded commands from the command FIFO and performs a single memory read or write per command.
- Serialises a response byte stream toward the UART TX path.
- Closes the host-to-memory loop: rx → byte FIFO → parser → cmd FIFO → cmd_executor → memory port / tx byte stream.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 32, memory data width; must be a multiple of 8. NB = DATA_W/8 response data bytes.
- TIMEOUT_CYC, 256, maximum cycles waited for mem_rvalid after a read request.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- cmd_fifo_empty  in  1  command FIFO empty flag.
- cmd_fifo_rd_en  out  1  pop strobe; FIFO is first-word-fall-through, so fields are valid whenever empty=0.
- cmd_opcode  in  8  head-of-FIFO opcode.
- cmd_addr  in  ADDR_W  head-of-FIFO address.
- cmd_wdata  in  DATA_W  head-of-FIFO write data.
- mem_req  out  1  one-cycle memory request strobe.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, qualified by mem_rvalid.
- mem_rvalid  in  1  read data valid.
- tx_data  out  8  response byte.
- tx_valid  out  1  response byte valid.
- tx_ready  in  1  downstream accepts byte.
- busy  out  1  high in any state other than IDLE.
- err_count  out  8  saturating count of bad-opcode and timeout events.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE.
  - All outputs 0: cmd_fifo_rd_en, mem_req, mem_we, mem_addr, mem_wdata, tx_data, tx_valid, busy, err_count.
  - Internal latches, byte counter and timeout counter cleared.
  - Reset mid-transaction abandons it: no response bytes, no further mem_req, no pop while rst=0.
- States: IDLE, DECODE, WRITE, READ_REQ, READ_WAIT, SEND_HDR, SEND_DATA.
- IDLE:
  - If cmd_fifo_empty=0: cmd_fifo_rd_en=1 for exactly this cycle (combinational from state & !empty). Latch opcode/addr/wdata on the same edge. Go to DECODE.
  - Otherwise stay in IDLE.
  - At most one pop per command; cmd_fifo_rd_en is never high outside IDLE.
- DECODE (1 cycle):
  - 0x57 'W' → WRITE.
  - 0x52 'R' → READ_REQ.
  - Any other opcode → resp=0x45 'E', err_count+1, go to SEND_HDR.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values, for one cycle.
  - Then resp=0x4B 'K', go to SEND_HDR. Writes are fire-and-forget; no ack is expected.
- READ_REQ:
  - mem_req=1, mem_we=0, mem_addr = latched address, for one cycle.
  - Clear timeout counter, go to READ_WAIT.
- READ_WAIT:
  - mem_rvalid=1: capture mem_rdata, resp=0x44 'D', go to SEND_HDR. Same-cycle response (rvalid in the first READ_WAIT cycle) is legal.
  - Counter reaches TIMEOUT_CYC-1 with no rvalid: resp=0x54 'T', err_count+1, go to SEND_HDR.
  - mem_rvalid in any other state is ignored. Late data after a timeout is dropped.
- SEND_HDR:
  - tx_valid=1, tx_data=resp.
  - On tx_valid&tx_ready: if resp=='D', go to SEND_DATA with byte index 0; else go to IDLE.
- SEND_DATA:
  - Sends the NB bytes of captured read data, MSB byte first.
  - Index advances only on tx_valid&tx_ready. After byte NB-1 is accepted, go to IDLE.
- TX handshake:
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without a transfer.
  - Back-to-back bytes are allowed: one byte per cycle when tx_ready is held high.
- err_count saturates at 255 and does not wrap.
- Latency with tx_ready=1 and an immediately available command:
  - Write: pop → 'K' on tx in cycle 3 after pop (IDLE, DECODE, WRITE, SEND_HDR).
  - Read: header appears 1 cycle after rvalid.
- busy=0 only in IDLE.
- Commands arriving while busy remain in the FIFO. Back-to-back commands re-enter IDLE for 1 cycle between them.

Test Plan:
- Write: push {0x57, addr 0x0010, data 0xDEADBEEF}, tx_ready=1.
  - Expect one cmd_fifo_rd_en pulse.
  - Expect one mem_req with mem_we=1, addr 0x0010, wdata 0xDEADBEEF.
  - Expect tx stream exactly 0x4B; busy returns to 0.
- Read: push {0x52, addr 0x0020}; memory model returns 0x12345678 3 cycles after mem_req.
  - Expect mem_we=0.
  - Expect tx stream 0x44, 0x12, 0x34, 0x56, 0x78.
- Backpressure: same read with tx_ready toggled 1-0-0-1 pseudo-randomly.
  - Expect identical byte sequence.
  - Expect tx_data stable whenever tx_valid=1 and tx_ready=0; no byte lost or duplicated.
- Errors:
  - Opcode 0x99 → tx 0x45, err_count=1, no mem_req.
  - Read with memory model never asserting rvalid → after 256 READ_WAIT cycles tx 0x54, err_count=2.
  - Force 300 bad opcodes → err_count holds at 255.
- Back-to-back: FIFO preloaded with W, R, W.
  - Expect three pops in order, each after the previous response completes.
  - Expect tx 0x4B, 0x44 + 4 data bytes, 0x4B.
- Reset mid-read: assert rst=0 during SEND_DATA after 2 data bytes.
  - Expect all outputs 0 on the next edge.
  - After release, no stale bytes are sent and the next queued command executes normally.
